// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter.
// Holds the default line and address widths, the arbiter state encoding and the
// requester identifier used by the optional round-robin last-grant register.
package mem_arb_pkg;

    localparam int unsigned DATA_W_DEF = 256;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntD = 2'd1,
        StGntI = 2'd2
    } arb_state_e;

    typedef enum logic {
        SrcD = 1'b0,
        SrcI = 1'b1
    } arb_src_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one data-memory port between a data cache (D)
// and an instruction cache (I).
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   d_enable_i/d_write_i/d_addr_i/d_data_i   data-cache request and write line
//   d_data_o/d_ack_o             data-cache read line and acknowledge
//   i_enable_i/i_write_i/i_addr_i/i_data_i   instruction-cache request and write line
//   i_data_o/i_ack_o             instruction-cache read line and acknowledge
//   mem_enable_o/mem_write_o/mem_addr_o/mem_data_o   shared memory request
//   mem_data_i/mem_ack_i         shared memory response
//
// Configuration macro: ARB_ROUND_ROBIN_EN. When defined, simultaneous requests are
// resolved by a 1-bit last-grant register (the requester not granted last wins).
// When undefined, the data cache has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_data_i,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_ack_o,
    input  logic              i_enable_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [DATA_W-1:0] i_data_i,
    output logic [DATA_W-1:0] i_data_o,
    output logic              i_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_e state_q, state_d;
    arb_src_e   winner;

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_e last_q, last_d;
`endif

    // Requester that would be granted if the arbiter were idle this cycle.
    always_comb begin
        winner = SrcD;
        if (!d_enable_i && i_enable_i) begin
            winner = SrcI;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (d_enable_i && i_enable_i && (last_q == SrcD)) begin
            winner = SrcI;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (d_enable_i || i_enable_i) begin
                    state_d = (winner == SrcI) ? StGntI : StGntD;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                end
            end
            // Grant is held until ack even if the requester drops its enable.
            StGntD, StGntI: begin
                if (mem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value "I granted last" makes the data cache win the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= SrcI;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Memory-side request and ack routing follow the granted requester.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        d_ack_o      = 1'b0;
        i_ack_o      = 1'b0;
        unique case (state_q)
            StGntD: begin
                mem_enable_o = 1'b1;
                mem_write_o  = d_write_i;
                mem_addr_o   = d_addr_i;
                mem_data_o   = d_data_i;
                d_ack_o      = mem_ack_i;
            end
            StGntI: begin
                mem_enable_o = 1'b1;
                mem_write_o  = i_write_i;
                mem_addr_o   = i_addr_i;
                mem_data_o   = i_data_i;
                i_ack_o      = mem_ack_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; the ack qualifies it.
    assign d_data_o = mem_data_i;
    assign i_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random cache traffic against a memory
// responder, a bus-ownership reference model and per-requester response queues.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned DW    = DATA_W_DEF;
    localparam int unsigned AW    = ADDR_W_DEF;
    localparam int          N_TXN = 24;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          d_enable_i, d_write_i, i_enable_i, i_write_i;
    logic [AW-1:0] d_addr_i, i_addr_i;
    logic [DW-1:0] d_data_i, i_data_i, d_data_o, i_data_o;
    logic          d_ack_o, i_ack_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t d_exp[$];
    exp_t i_exp[$];
    logic [DW-1:0] ref_mem  [bit [AW-1:0]];
    logic [DW-1:0] phys_mem [bit [AW-1:0]];
    bit   resp_en = 1'b1;

    // Ownership model: 0 = nobody, 1 = data cache, 2 = instruction cache.
    int   own;
    bit   last_was_i;

    mem_arbiter u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .d_enable_i  (d_enable_i),
        .d_write_i   (d_write_i),
        .d_addr_i    (d_addr_i),
        .d_data_i    (d_data_i),
        .d_data_o    (d_data_o),
        .d_ack_o     (d_ack_o),
        .i_enable_i  (i_enable_i),
        .i_write_i   (i_write_i),
        .i_addr_i    (i_addr_i),
        .i_data_i    (i_data_i),
        .i_data_o    (i_data_o),
        .i_ack_o     (i_ack_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a) ^ 32'hDEAD_BEEF;
        return {(DW/32){w}};
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < int'(DW / 32); j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_line(a);
    endfunction

    function automatic logic [DW-1:0] phys_read(input logic [AW-1:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return init_line(a);
    endfunction

    // Winner of a simultaneous request given who was granted last.
    function automatic int tie_pick(input bit last_i);
`ifdef ARB_ROUND_ROBIN_EN
        return last_i ? 1 : 2;
`else
        return (last_i || !last_i) ? 1 : 1;
`endif
    endfunction

    function automatic int pick(input logic de, input logic ie, input bit last_i);
        if (de && ie) return tie_pick(last_i);
        return de ? 1 : 2;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            own        <= 0;
            last_was_i <= 1'b1;
        end else if (own == 0 && (d_enable_i || i_enable_i)) begin
            own        <= pick(d_enable_i, i_enable_i, last_was_i);
            last_was_i <= (pick(d_enable_i, i_enable_i, last_was_i) == 2);
        end else if (own != 0 && mem_ack_i) begin
            own <= 0;
        end
    end

    // Monitor: bus routing against the ownership model, acks against the queues.
    always @(negedge clk_i) begin
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        exp_t          e;
        e_wr   = 1'b0;
        e_addr = '0;
        e_data = '0;
        if (own == 1) begin
            e_wr = d_write_i; e_addr = d_addr_i; e_data = d_data_i;
        end else if (own == 2) begin
            e_wr = i_write_i; e_addr = i_addr_i; e_data = i_data_i;
        end
        check("mem_enable", DW'(mem_enable_o), DW'(own != 0));
        check("mem_write", DW'(mem_write_o), DW'(e_wr));
        check("mem_addr", DW'(mem_addr_o), DW'(e_addr));
        check("mem_wdata", mem_data_o, e_data);
        check("d_ack", DW'(d_ack_o), DW'(own == 1 && mem_ack_i));
        check("i_ack", DW'(i_ack_o), DW'(own == 2 && mem_ack_i));
        check("d_rdata_bcast", d_data_o, mem_data_i);
        check("i_rdata_bcast", i_data_o, mem_data_i);
        if (d_ack_o) begin
            if (d_exp.size() == 0) begin
                check("d_ack_unexpected", DW'(1), DW'(0));
            end else begin
                e = d_exp.pop_front();
                if (!e.wr) check("d_read_line", d_data_o, e.data);
            end
        end
        if (i_ack_o) begin
            if (i_exp.size() == 0) begin
                check("i_ack_unexpected", DW'(1), DW'(0));
            end else begin
                e = i_exp.pop_front();
                if (!e.wr) check("i_read_line", i_data_o, e.data);
            end
        end
    end

    // Memory responder: random latency, occasional stray ack while idle.
    initial begin
        int wait_cnt;
        wait_cnt   = -1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_ack_i  = 1'b0;
            mem_data_i = rand_line();
            if (!rst_i || !resp_en) begin
                wait_cnt = -1;
            end else if (mem_enable_o) begin
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 4));
                if (wait_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) phys_mem[mem_addr_o] = mem_data_o;
                    else mem_data_i = phys_read(mem_addr_o);
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack_i = 1'b1;
            end
        end
    end

    task automatic drive(input bit is_d, input logic en, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (is_d) begin
            d_enable_i = en; d_write_i = wr; d_addr_i = addr; d_data_i = wdata;
        end else begin
            i_enable_i = en; i_write_i = wr; i_addr_i = addr; i_data_i = wdata;
        end
    endtask

    // Issue one request, record its expected response, wait (bounded) for the ack.
    task automatic do_txn(input bit is_d, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        exp_t e;
        bit   ok;
        ok     = 1'b0;
        e.wr   = wr;
        e.data = wr ? '0 : ref_read(addr);
        if (wr) ref_mem[addr] = wdata;
        if (is_d) d_exp.push_back(e);
        else i_exp.push_back(e);
        drive(is_d, 1'b1, wr, addr, wdata);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            if (is_d ? d_ack_o : i_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(is_d ? "d_ack_timeout" : "i_ack_timeout", DW'(0), DW'(1));
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_req(input bit is_d);
        logic [AW-1:0] base;
        base = is_d ? AW'(32'h1000) : AW'(32'h8000);
        for (int k = 0; k < N_TXN; k++) begin
            do_txn(is_d, 1'($urandom_range(0, 1)), base + AW'(32 * $urandom_range(0, 7)),
                   rand_line());
            // Sometimes release enable, otherwise re-request back to back.
            if ($urandom_range(0, 2) == 0) begin
                drive(is_d, 1'b0, 1'b0, '0, '0);
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        drive(is_d, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Single data-cache read of 0x400.
        do_txn(1'b1, 1'b0, AW'(32'h400), '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Instruction-cache line write with a data-cache request arriving during it.
        fork
            begin
                do_txn(1'b0, 1'b1, AW'(32'h80), {(DW/8){8'hA5}});
                drive(1'b0, 1'b0, 1'b0, '0, '0);
            end
            begin
                @(posedge clk_i);
                #1;
                do_txn(1'b1, 1'b0, AW'(32'h1020), '0);
                drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        join

        // Data-cache write-back then refill with enable held high.
        do_txn(1'b1, 1'b1, AW'(32'h1000), rand_line());
        do_txn(1'b1, 1'b0, AW'(32'h1040), '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Simultaneous requests and random traffic from both caches.
        fork
            run_req(1'b1);
            run_req(1'b0);
        join

        // Reset during a data-cache grant with the responder silenced.
        resp_en = 1'b0;
        drive(1'b1, 1'b1, 1'b0, AW'(32'h400), '0);
        @(posedge clk_i);
        #1;
        check("rst_pre_grant", DW'(mem_enable_o), DW'(1));
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_mem_enable", DW'(mem_enable_o), DW'(0));
        check("rst_d_ack", DW'(d_ack_o), DW'(0));
        check("rst_mem_addr", DW'(mem_addr_o), DW'(0));
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        resp_en = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        check("idle_after_rst", DW'(mem_enable_o), DW'(0));
        check("d_queue_drained", DW'(d_exp.size()), DW'(0));
        check("i_queue_drained", DW'(i_exp.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 256, memory line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have ports d_enable_i, d_write_i (input, 1) and d_addr_i (input, ADDR_W): data-cache request.
REQ-006 SHALL have ports d_data_i (input, DATA_W), d_data_o (output, DATA_W) and d_ack_o (output, 1): data-cache write data, read data and acknowledge.
REQ-007 SHALL have ports i_enable_i, i_write_i (input, 1) and i_addr_i (input, ADDR_W): instruction-cache request.
REQ-008 SHALL have ports i_data_i (input, DATA_W), i_data_o (output, DATA_W) and i_ack_o (output, 1): instruction-cache write data, read data and acknowledge.
REQ-009 SHALL have ports mem_enable_o, mem_write_o (output, 1), mem_addr_o (output, ADDR_W) and mem_data_o (output, DATA_W): shared data-memory request.
REQ-010 SHALL have ports mem_data_i (input, DATA_W) and mem_ack_i (input, 1): shared data-memory response.

Function
REQ-011 SHALL implement states IDLE, GNT_D and GNT_I, held in a 2-bit register.
REQ-012 IDLE: if any *_enable_i is high, SHALL register the grant and enter GNT_D or GNT_I on the next edge; otherwise SHALL stay in IDLE.
REQ-013 Arbitration between simultaneous requests SHALL follow REQ-024/025; a single requester SHALL always win.
REQ-014 In GNT_x: mem_enable_o SHALL be high; mem_write_o, mem_addr_o and mem_data_o SHALL combinationally follow requester x.
REQ-015 In IDLE: mem_enable_o and mem_write_o SHALL be 0, mem_addr_o SHALL be 0, and mem_data_o SHALL be 0.
REQ-016 mem_ack_i SHALL be routed only to the granted requester's *_ack_o; the other ack SHALL be 0.
REQ-017 Both ack outputs SHALL be 0 in IDLE.
REQ-018 mem_data_i SHALL drive both d_data_o and i_data_o unconditionally; validity is qualified by the ack.
REQ-019 In GNT_x, on mem_ack_i high, SHALL return to IDLE, leaving exactly one IDLE cycle before the next grant; latency from request to mem_enable_o is 1 cycle.
REQ-020 Grant SHALL be held until ack, even if the granted requester drops its enable; a stray ack in IDLE SHALL be ignored.
REQ-021 A requester that keeps enable high after its ack (e.g. write-back followed by refill) SHALL re-arbitrate as a new request.

Reset
REQ-022 On rst_i low, SHALL asynchronously force IDLE, the priority pointer to "data cache next", and all outputs to the REQ-015/017 values.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction, with no ack issued.

Configuration
REQ-024 With ARB_ROUND_ROBIN_EN defined, SHALL keep a 1-bit last-grant register; on a tie, the requester not granted last SHALL win; the register updates on each grant.
REQ-025 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority (data cache over instruction cache), with no last-grant register.

Structure
REQ-026 State encodings and DATA_W/ADDR_W defaults SHALL live in shared package mem_arb_pkg.
REQ-027 The block SHALL be a single module with no sub-module; the optional priority logic SHALL sit inside the module under the macro.

Verification
REQ-028 d_enable_i=1, d_write_i=0, d_addr_i=0x0000_0400, ack after 10 cycles -> mem_enable_o high 1 cycle later, mem_addr_o=0x400, d_ack_o pulses once, i_ack_o=0.
REQ-029 Both request in the same cycle, round-robin on -> D granted first, then I after 1 IDLE cycle; with macro off and D re-requesting -> D granted twice before I.
REQ-030 I granted, writing line 0xA5..A5 to 0x80, then D requests mid-transaction -> mem_data_o/mem_addr_o stay I's until ack; D granted afterwards.
REQ-031 D write-back to 0x1000 then refill from 0x2000, enable held high -> two separate grants, mem_write_o 1 then 0, two d_ack_o pulses.
REQ-032 rst_i low during GNT_D -> mem_enable_o=0 immediately, no ack, IDLE after release; mem_ack_i pulse in IDLE -> both acks stay 0.
